// File: rtl/calc_disp_pkg.sv
// Shared constants and types for the calculator seven-segment display path.
package calc_disp_pkg;

  localparam int unsigned NUM_DIGITS = 5;
  localparam int unsigned BIN_W      = 16;
  localparam int unsigned BCD_W      = 4 * NUM_DIGITS;
  localparam int unsigned SEG_W      = 8;

  // Active-low segment patterns, bit0..6 = a..g, bit7 = dp (held off)
  localparam logic [SEG_W-1:0] SEG_0     = 8'hC0;
  localparam logic [SEG_W-1:0] SEG_1     = 8'hF9;
  localparam logic [SEG_W-1:0] SEG_2     = 8'hA4;
  localparam logic [SEG_W-1:0] SEG_3     = 8'hB0;
  localparam logic [SEG_W-1:0] SEG_4     = 8'h99;
  localparam logic [SEG_W-1:0] SEG_5     = 8'h92;
  localparam logic [SEG_W-1:0] SEG_6     = 8'h82;
  localparam logic [SEG_W-1:0] SEG_7     = 8'hF8;
  localparam logic [SEG_W-1:0] SEG_8     = 8'h80;
  localparam logic [SEG_W-1:0] SEG_9     = 8'h90;
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_COMMIT
  } state_e;

  function automatic logic [SEG_W-1:0] seg_encode(input logic [3:0] digit);
    logic [SEG_W-1:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift/add-3 binary-to-BCD converter; one input bit per cycle.
module bin2bcd_seq
  import calc_disp_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic [BCD_W-1:0] bcd,
  output logic             done_c
);

  localparam int unsigned CNT_W = $clog2(BIN_W);

  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic [BCD_W-1:0] adj;

  always_comb begin
    adj   = bcd_q;
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    run_d = run_q;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
    if (start) begin
      bin_d = bin_in;
      bcd_d = '0;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      {bcd_d, bin_d} = {adj, bin_q} << 1;
      cnt_d          = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(BIN_W - 1)) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  // Asserted during the final shift cycle
  assign done_c = run_q && (cnt_q == CNT_W'(BIN_W - 1));
  assign bcd    = bcd_q;

endmodule

// File: rtl/display_scan_ctrl.sv
// Converts a loaded result to BCD, commits it atomically, and multiplexes
// the digits onto the active-low segment and digit-select pins.
module display_scan_ctrl
  import calc_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BIN_W-1:0] value,
  input  logic             value_load,
  output logic             busy,
  output logic [SEG_W-1:0] indicator,
  output logic [SEG_W-1:0] indicator_choice
);

  localparam int unsigned PRE_W = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W = 3;

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic [BIN_W-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic [BCD_W-1:0] shown_q, shown_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SEG_W-1:0] ind_q, ind_d;
  logic [SEG_W-1:0] choice_q, choice_d;

  logic             start_c;
  logic [BIN_W-1:0] start_val;
  logic [BCD_W-1:0] conv_bcd;
  logic             conv_done_c;
  logic             tick_c;
  logic [IDX_W-1:0] idx_next;
  logic [3:0]       digit;
  logic [NUM_DIGITS:0] upper_nz;

  bin2bcd_seq u_bin2bcd (
    .clk    (clk),
    .reset  (reset),
    .start  (start_c),
    .bin_in (start_val),
    .bcd    (conv_bcd),
    .done_c (conv_done_c)
  );

  // Conversion sequencing; loads arriving while busy collapse into one pending slot
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    pend_v_d  = pend_v_q;
    shown_d   = shown_q;
    start_c   = 1'b0;
    start_val = value;
    case (state_q)
      ST_IDLE: begin
        if (value_load) begin
          start_c  = 1'b1;
          pend_v_d = 1'b0;
          state_d  = ST_CONVERT;
        end else if (pend_v_q) begin
          start_c   = 1'b1;
          start_val = pend_q;
          pend_v_d  = 1'b0;
          state_d   = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (value_load) begin
          pend_d   = value;
          pend_v_d = 1'b1;
        end
        if (conv_done_c) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        if (value_load) begin
          pend_d   = value;
          pend_v_d = 1'b1;
        end
        shown_d = conv_bcd;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Digit scanner with leading-zero blanking from the committed digits only
  always_comb begin
    tick_c   = (presc_q == PRE_W'(REFRESH_DIV - 1));
    presc_d  = tick_c ? '0 : presc_q + PRE_W'(1);
    idx_next = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    upper_nz = '0;
    for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
      upper_nz[k] = (shown_q[4*k +: 4] != 4'd0) || upper_nz[k+1];
    end
    digit    = shown_q[{idx_next, 2'b00} +: 4];
    idx_d    = idx_q;
    ind_d    = ind_q;
    choice_d = choice_q;
    if (tick_c) begin
      idx_d    = idx_next;
      choice_d = ~(SEG_W'(1) << idx_next);
      ind_d    = ((idx_next != IDX_W'(0)) && !upper_nz[idx_next]) ? SEG_BLANK : seg_encode(digit);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      shown_q  <= '0;
      presc_q  <= '0;
      idx_q    <= '0;
      ind_q    <= SEG_BLANK;
      choice_q <= 8'hFF;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      shown_q  <= shown_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      ind_q    <= ind_d;
      choice_q <= choice_d;
    end
  end

  assign busy             = busy_q;
  assign indicator        = ind_q;
  assign indicator_choice = choice_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: decimal reference model for the scan
// and a cycle model of the conversion sequencer.
module tb_display_scan_ctrl;

  localparam int unsigned DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] value = '0;
  logic        value_load = 1'b0;
  logic        busy;
  logic [7:0]  indicator;
  logic [7:0]  indicator_choice;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  display_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
    .clk              (clk),
    .reset            (reset),
    .value            (value),
    .value_load       (value_load),
    .busy             (busy),
    .indicator        (indicator),
    .indicator_choice (indicator_choice)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_seg(input int unsigned v, input int k);
    int unsigned p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    if (k > 0 && v < p) return 8'hFF;
    case ((v / p) % 10)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  // Expected committed values, pushed when a conversion is accepted
  int unsigned exp_q[$];
  int          m_cnt = 0;
  bit          m_pend_v = 1'b0;
  int unsigned m_pend = 0;
  int          m_presc = 0;
  bit          m_tick = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cnt    = 0;
      m_pend_v = 1'b0;
      m_presc  = 0;
      m_tick   = 1'b0;
      exp_q.delete();
    end else begin
      m_tick  = (m_presc == int'(DIV) - 1);
      m_presc = m_tick ? 0 : m_presc + 1;
      if (m_cnt == 0) begin
        if (value_load) begin
          exp_q.push_back(32'(value));
          m_pend_v = 1'b0;
          m_cnt    = 17;
        end else if (m_pend_v) begin
          exp_q.push_back(m_pend);
          m_pend_v = 1'b0;
          m_cnt    = 17;
        end
      end else begin
        if (value_load) begin
          m_pend   = 32'(value);
          m_pend_v = 1'b1;
        end
        m_cnt--;
      end
    end
  end

  // Monitor: a tick scans the value shown before any commit on the same edge
  bit          prev_busy = 1'b0;
  int unsigned cur_shown = 0;
  int          m_idx = 0;
  logic [7:0]  e_ind = 8'hFF;
  logic [7:0]  e_choice = 8'hFF;

  always @(negedge clk) begin
    if (!reset) begin
      prev_busy = 1'b0;
      cur_shown = 0;
      m_idx     = 0;
      e_ind     = 8'hFF;
      e_choice  = 8'hFF;
    end else begin
      if (m_tick) begin
        m_idx    = (m_idx == 4) ? 0 : m_idx + 1;
        e_choice = 8'hFF & ~(8'h01 << m_idx);
        e_ind    = exp_seg(cur_shown, m_idx);
      end
      if (prev_busy && !busy) begin
        check_eq("sb_pop", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) cur_shown = exp_q.pop_front();
      end
      prev_busy = busy;
    end
    check_eq("busy", 32'(busy), 32'(m_cnt != 0));
    check_eq("indicator", 32'(indicator), 32'(e_ind));
    check_eq("choice", 32'(indicator_choice), 32'(e_choice));
  end

  task automatic load(input logic [15:0] v);
    @(posedge clk);
    #1;
    value      = v;
    value_load = 1'b1;
    @(posedge clk);
    #1;
    value_load = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    idle(3);
    #1 reset = 1'b1;
    idle(25);

    load(16'd1234);
    idle(40);
    load(16'd65535);
    idle(40);
    load(16'd0);
    idle(40);
    load(16'd100);
    idle(40);

    load(16'd42);
    idle(3);
    load(16'd7);
    idle(2);
    load(16'd9);
    idle(60);

    load(16'd321);
    idle(15);
    load(16'd8);
    idle(60);

    load(16'd5000);
    idle(7);
    #1 reset = 1'b0;
    idle(3);
    #1 reset = 1'b1;
    idle(40);

    check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Controller that sequences the calculator's seven-segment display path. It accepts a 16-bit unsigned result, converts it to five BCD digits with a sequential shift-add-3 engine, and commits the digits atomically to a display register. It then time-multiplexes the digits onto the segment and digit-select outputs with leading-zero blanking. It sits between the calculator core's result register and the board's indicator pins.

## Interface

- REFRESH_DIV, default 50000: clk cycles per digit slot; minimum 2.
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset; deasserted synchronously by the board reset logic.
- value  in  16  unsigned binary value to display.
- value_load  in  1  one-cycle request to display `value`.
- busy  out  1  conversion in progress (states CONVERT or COMMIT).
- indicator  out  8  segments, active-low: bit0..6 = a..g, bit7 = dp (always 1, off).
- indicator_choice  out  8  digit select, active-low one-hot: bit0 = ones digit; bits 5..7 always 1.

## Operation

- FSM states: IDLE, CONVERT, COMMIT.
  - IDLE goes to CONVERT on value_load, or on pending_valid.
  - CONVERT lasts exactly 16 cycles, then goes to COMMIT.
  - COMMIT lasts 1 cycle, then goes to IDLE.
- Load in IDLE: `value` is captured into a 16-bit shift register and the 20-bit BCD register is cleared.
- Load while busy: `value` is stored in a pending register and pending_valid is set. A later load while busy overwrites it, so the latest value wins. Pending is consumed on the cycle after COMMIT, when the FSM is in IDLE.
- Each CONVERT cycle does two things in one cycle:
  - every BCD nibble ≥5 gets +3;
  - then {bcd, bin} shifts left by 1.
- COMMIT copies the 20-bit BCD into the shown register. The scanner only reads the shown register, so a partial conversion is never displayed.
- Scanner:
  - A prescaler counts 0..REFRESH_DIV-1. On the wrap it emits tick and resets to 0.
  - On tick, the digit index advances 0→1→2→3→4→0.
  - Also on tick, indicator and indicator_choice are registered for the new index.
- Blanking: digit k>0 is blanked (indicator=8'hFF, select still driven) when shown digits k..4 are all zero. Digit 0 is never blanked.
- Segment codes (bits 7..0), from the shared package:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - blank=FF.
  - Nibbles >9 cannot occur; if one does, output blank.

## Timing

- Reset values:
  - state IDLE, busy 0, pending_valid 0, bcd and shown 0;
  - prescaler 0, index 0;
  - indicator 8'hFF, indicator_choice 8'hFF.
- Reset asserted mid-conversion: everything returns to the reset values immediately. The shown register keeps nothing.
- value_load sampled at cycle T while idle:
  - busy=1 during cycles T+1..T+17;
  - shown is updated at the edge ending cycle T+17;
  - busy=0 at T+18.
- Back-to-back: a pending load restarts CONVERT at T+18, so busy drops for exactly one cycle.
- The first scan output after reset appears at the first tick: REFRESH_DIV cycles after reset release, showing index 1.
- New digits become visible at the first tick after COMMIT. Display latency from load is at most 17 + REFRESH_DIV cycles per slot.
- A load in the same cycle as COMMIT goes to pending.

## Structure

- Package `calc_disp_pkg` holds:
  - the SEG_0..SEG_9 and SEG_BLANK constants;
  - the NUM_DIGITS=5 constant;
  - the FSM state enum typedef.
- Sub-module `bin2bcd_seq` implements the shift/add-3 datapath and the 16-cycle counter, with start/done handshaking.
- The scanner, pending logic and FSM live in the top module.

## Test plan

All scenarios use REFRESH_DIV=4.

- Reset: hold reset low, then release → indicator=FF, choice=FF, busy=0 until the first tick; then index 1 is selected and blanked (value 0).
- Load 1234 → busy high for 17 cycles. Across five ticks:
  - digit0 = 99 with choice FE;
  - digit1 = B0 with choice FD;
  - digit2 = A4 with choice FB;
  - digit3 = F9 with choice F7;
  - digit4 = FF with choice EF.
- Load 65535 → shown digits 5,3,5,5,6; no blanking.
- Load 0 and load 100 → digit0 C0 in both cases; for 100, digits 3..4 are blank and digit1 = C0 (an internal zero is not blanked).
- Load 42, then load 7 at cycle T+5 and load 9 at T+9 → 42 is committed, then 9 is committed with busy low for one cycle. 7 is never shown.
- Load 5000, then assert reset at T+8 → all outputs return to reset values, and 5000 is never shown after release.
